// File: rtl/div_disp_pkg.sv
// Shared defaults and state encoding for the divider-result BCD readout.
package div_disp_pkg;

  localparam int DEF_IN_WIDTH = 17;
  localparam int DEF_DIGITS   = 5;
  // One shift-add-3 step per input bit.
  localparam int CONV_CYCLES  = DEF_IN_WIDTH;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    CONVERT = ST_CONVERT,
    DONE    = ST_DONE
  } state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/div_result_bcd.sv
// Converts a signed divider result to sign + BCD magnitude, one bit per clock,
// with a leading-zero blanking mask for the display.
module div_result_bcd
  import div_disp_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int DIGITS   = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [IN_WIDTH-1:0]   value_in,
  output logic                  busy,
  output logic                  valid_out,
  output logic                  sign_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  dropped
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(IN_WIDTH - 1);

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [IN_WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [CW-1:0]       count_q, count_d;
  logic                sign_out_q, sign_out_d;
  logic [BW-1:0]       bcd_out_q, bcd_out_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                valid_out_q, valid_out_d;
  logic                dropped_q, dropped_d;

  logic [BW-1:0]       bcd_adj;
  logic [DIGITS-1:0]   digit_en_w;
  logic                any_nz;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_i (bcd_q[4*g +: 4]),
      .d_o (bcd_adj[4*g +: 4])
    );
  end

  // A digit is shown if it or any more significant digit is nonzero; units always shown.
  always_comb begin
    any_nz     = 1'b0;
    digit_en_w = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz        = any_nz | (bcd_q[4*i +: 4] != 4'd0);
      digit_en_w[i] = any_nz;
    end
    digit_en_w[0] = 1'b1;
  end

  // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    count_d     = count_q;
    sign_out_d  = sign_out_q;
    bcd_out_d   = bcd_out_q;
    digit_en_d  = digit_en_q;
    valid_out_d = 1'b0;
    dropped_d   = valid_in && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          sign_d  = value_in[IN_WIDTH-1];
          // Unsigned magnitude: the most negative input maps to 2^(IN_WIDTH-1) without overflow.
          mag_d   = value_in[IN_WIDTH-1] ? (~value_in + 1'b1) : value_in;
          bcd_d   = '0;
          count_d = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d   = {bcd_adj[BW-2:0], mag_q[IN_WIDTH-1]};
        mag_d   = {mag_q[IN_WIDTH-2:0], 1'b0};
        count_d = count_q + 1'b1;
        if (count_q == LAST_SHIFT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        sign_out_d  = sign_q;
        bcd_out_d   = bcd_q;
        digit_en_d  = digit_en_w;
        valid_out_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      count_q     <= '0;
      sign_out_q  <= 1'b0;
      bcd_out_q   <= '0;
      digit_en_q  <= '0;
      valid_out_q <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      count_q     <= count_d;
      sign_out_q  <= sign_out_d;
      bcd_out_q   <= bcd_out_d;
      digit_en_q  <= digit_en_d;
      valid_out_q <= valid_out_d;
      dropped_q   <= dropped_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign valid_out = valid_out_q;
  assign sign_out  = sign_out_q;
  assign bcd_out   = bcd_out_q;
  assign digit_en  = digit_en_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Scoreboard bench for div_result_bcd: a cycle-level acceptance model feeds expected
// results into a queue, and a negedge monitor checks every output against it.
module tb_div_result_bcd;

  localparam int W = 17;
  localparam int D = 5;
  localparam int LAT = W + 1;   // accept edge to valid_out edge
  localparam int PERIOD = W + 2; // accept edge to next possible accept edge

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           valid_in = 1'b0;
  logic [W-1:0]   value_in = '0;
  logic           busy, valid_out, sign_out, dropped;
  logic [4*D-1:0] bcd_out;
  logic [D-1:0]   digit_en;

  div_result_bcd #(.IN_WIDTH(W), .DIGITS(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .value_in  (value_in),
    .busy      (busy),
    .valid_out (valid_out),
    .sign_out  (sign_out),
    .bcd_out   (bcd_out),
    .digit_en  (digit_en),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             due;
    logic           sign;
    logic [4*D-1:0] bcd;
    logic [D-1:0]   en;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  bit acc_valid = 1'b0;
  bit started   = 1'b0;
  bit exp_drop  = 1'b0;
  logic           held_sign = 1'b0;
  logic [4*D-1:0] held_bcd  = '0;
  logic [D-1:0]   held_en   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal reference: digits by division, blanking by magnitude comparison.
  function automatic exp_t model(input logic [W-1:0] raw, input int due);
    exp_t e;
    int v, mag, p;
    v   = int'($signed(raw));
    mag = (v < 0) ? -v : v;
    e.due  = due;
    e.sign = (v < 0);
    e.bcd  = '0;
    e.en   = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      e.bcd[4*i +: 4] = 4'((mag / p) % 10);
      e.en[i]         = (i == 0) || (mag >= p);
      p = p * 10;
    end
    return e;
  endfunction

  // Acceptance model: one conversion in flight, next accept PERIOD edges later.
  always @(posedge clk) begin
    bit in_flight;
    cyc++;
    if (!reset) begin
      started   = 1'b1;
      acc_valid = 1'b0;
      exp_drop  = 1'b0;
      sb.delete();
      held_sign = 1'b0;
      held_bcd  = '0;
      held_en   = '0;
    end else begin
      in_flight = acc_valid && (cyc < acc_cyc + PERIOD);
      exp_drop  = valid_in && in_flight;
      if (valid_in && !in_flight) begin
        acc_cyc   = cyc;
        acc_valid = 1'b1;
        sb.push_back(model(value_in, cyc + LAT));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      check("busy", 32'(busy), 32'(acc_valid && cyc >= acc_cyc && cyc < acc_cyc + LAT));
      check("dropped", 32'(dropped), 32'(exp_drop));
      if (valid_out) begin
        if (sb.size() == 0) begin
          check("unexpected_valid_out", 32'(valid_out), 32'd0);
        end else begin
          e = sb.pop_front();
          check("latency", 32'(cyc), 32'(e.due));
          held_sign = e.sign;
          held_bcd  = e.bcd;
          held_en   = e.en;
        end
      end else begin
        while (sb.size() > 0 && cyc >= sb[0].due) begin
          e = sb.pop_front();
          check("missing_valid_out", 32'(valid_out), 32'd1);
        end
      end
      check("sign_out", 32'(sign_out), 32'(held_sign));
      check("bcd_out", 32'(bcd_out), 32'(held_bcd));
      check("digit_en", 32'(digit_en), 32'(held_en));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int v);
    valid_in = 1'b1;
    value_in = W'(v);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(2);

    pulse(-26);     idle(25);
    pulse(-65536);  idle(25);
    pulse(65535);   idle(25);
    pulse(0);       idle(25);

    // Collision: 999 offered at E5 is dropped, then accepted at E19.
    pulse(2);   idle(4);
    pulse(999); idle(13);
    pulse(999); idle(25);

    // Reset at E9 of an in-flight conversion.
    pulse(12345); idle(8);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(30);
    pulse(7); idle(25);

    // valid_in held high, value alternating every cycle.
    valid_in = 1'b1;
    for (int i = 0; i < 80; i++) begin
      value_in = (i % 2 == 0) ? W'(1) : W'(-1);
      @(negedge clk);
    end
    valid_in = 1'b0;
    idle(25);

    // Random traffic, including collisions.
    for (int i = 0; i < 700; i++) begin
      valid_in = ($urandom_range(0, 7) == 0);
      value_in = W'($urandom);
      @(negedge clk);
    end
    valid_in = 1'b0;
    idle(25);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
